// File: rtl/mac_rx_buf_wr.sv
`default_nettype none
// ============================================================================
// mac_rx_buf_wr : MAC RX frames -> circular 32-bit word buffer + descriptors
// Revision      : 1.0
// ============================================================================
module mac_rx_buf_wr #(
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter int MAX_BYTES = 9600
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_n_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [31:0]       buf_wdata_o,
  input  logic [ADDR_W:0]   buf_rptr_i,
  output logic [ADDR_W:0]   buf_wptr_o,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_start_o,
  output logic [15:0]       desc_len_o,
  output logic [15:0]       drop_cnt_o
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_read   = 2'd1;
  localparam logic [1:0] c_drop   = 2'd2;
  localparam logic [1:0] c_commit = 2'd3;

  localparam int LEN_W = 18;
  localparam logic [ADDR_W:0]  c_depth   = (ADDR_W+1)'(DEPTH);
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_BYTES);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_rqrd;
  logic [ADDR_W:0]   r_wptr_work;
  logic [ADDR_W:0]   r_wptr;
  logic [15:0]       r_word_cnt;
  logic [ADDR_W-1:0] r_frame_start;
  logic [15:0]       r_frame_len;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_desc_valid;
  logic [ADDR_W-1:0] r_desc_start;
  logic [15:0]       r_desc_len;
  logic [15:0]       r_drop_cnt;

  logic              w_started;
  logic              w_restart;
  logic [ADDR_W:0]   w_base_ptr;
  logic [15:0]       w_base_cnt;
  logic [ADDR_W:0]   w_base_used;
  logic [ADDR_W:0]   w_commit_used;
  logic              w_full;
  logic              w_idle_full;
  logic [LEN_W-1:0]  w_run_len;
  logic              w_accept;
  logic              w_overflow;
  logic              w_do_write;
  logic              w_good_eop;
  logic              w_bad_eop;
  logic              w_drop_eop;
  logic              w_load;
  logic [1:0]        w_drop_inc;
  logic [16:0]       w_drop_sum;

  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) r_state <= c_idle;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:   if (mac_rxda_i && !w_idle_full) w_next_state = c_read;
      c_read: begin
        if (w_good_eop)     w_next_state = c_commit;
        else if (w_bad_eop) w_next_state = c_idle;
        else if (w_overflow) w_next_state = c_drop;
      end
      c_drop:   if (w_drop_eop) w_next_state = c_idle;
      c_commit: if (w_load) w_next_state = c_idle;
      default:  w_next_state = c_idle;
    endcase
  end

  // A SOP arriving mid-frame restarts the frame from the committed pointer.
  always_comb begin
    w_started     = (r_word_cnt != 16'd0);
    w_restart     = (r_state == c_read) && mac_rxdv_i && mac_rxsop_i && w_started;
    w_base_ptr    = w_restart ? r_wptr : r_wptr_work;
    w_base_cnt    = mac_rxsop_i ? 16'd0 : r_word_cnt;
    w_base_used   = w_base_ptr - buf_rptr_i;
    w_commit_used = r_wptr - buf_rptr_i;
    w_full        = (w_base_used == c_depth);
    w_idle_full   = (w_commit_used == c_depth);
    w_run_len     = {w_base_cnt, 2'b00} +
                    (mac_rxeop_i ? (LEN_W'(mac_ben_i) + LEN_W'(1)) : LEN_W'(4));
    w_accept      = (r_state == c_read) && mac_rxdv_i && (w_started || mac_rxsop_i);
    w_overflow    = w_accept && (w_full || (w_run_len > c_max_len));
    w_do_write    = w_accept && !w_overflow;
    w_good_eop    = w_do_write && mac_rxeop_i;
    w_bad_eop     = w_overflow && mac_rxeop_i;
    w_drop_eop    = (r_state == c_drop) && mac_rxdv_i && mac_rxeop_i;
    w_load        = (r_state == c_commit) && (!r_desc_valid || desc_ready_i);
    w_drop_inc    = {1'b0, w_restart} + {1'b0, w_bad_eop} + {1'b0, w_drop_eop};
    w_drop_sum    = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};
  end

  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) begin
      r_rqrd        <= 1'b0;
      r_wptr_work   <= '0;
      r_wptr        <= '0;
      r_word_cnt    <= '0;
      r_frame_start <= '0;
      r_frame_len   <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_desc_valid  <= 1'b0;
      r_desc_start  <= '0;
      r_desc_len    <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_rqrd     <= (w_next_state == c_read) || (w_next_state == c_drop);
      r_we       <= w_do_write;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      if (w_do_write) begin
        r_waddr <= w_base_ptr[ADDR_W-1:0];
        r_wdata <= mac_rxd_i;
      end
      case (r_state)
        c_idle: begin
          r_wptr_work <= r_wptr;
          r_word_cnt  <= '0;
        end
        c_read: begin
          if (w_do_write) begin
            r_wptr_work <= w_base_ptr + (ADDR_W+1)'(1);
            r_word_cnt  <= w_base_cnt + 16'd1;
            if (mac_rxsop_i) r_frame_start <= w_base_ptr[ADDR_W-1:0];
            if (mac_rxeop_i) r_frame_len   <= w_run_len[15:0];
          end else if (w_restart || w_bad_eop) begin
            r_wptr_work <= r_wptr;
          end
        end
        c_drop:   if (w_drop_eop) r_wptr_work <= r_wptr;
        c_commit: if (w_load) r_wptr <= r_wptr_work;
        default: ;
      endcase
      if (w_load) begin
        r_desc_valid <= 1'b1;
        r_desc_start <= r_frame_start;
        r_desc_len   <= r_frame_len;
      end else if (r_desc_valid && desc_ready_i) begin
        r_desc_valid <= 1'b0;
      end
    end
  end

  assign mac_rxrqrd_o = r_rqrd;
  assign buf_we_o     = r_we;
  assign buf_waddr_o  = r_waddr;
  assign buf_wdata_o  = r_wdata;
  assign buf_wptr_o   = r_wptr;
  assign desc_valid_o = r_desc_valid;
  assign desc_start_o = r_desc_start;
  assign desc_len_o   = r_desc_len;
  assign drop_cnt_o   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_rx_buf_wr.sv
`default_nettype none
// ============================================================================
// tb_mac_rx_buf_wr : scoreboard bench with a frame-level reference model
// Revision         : 1.0
// ============================================================================
module tb_mac_rx_buf_wr;
  localparam int DEPTH = 4096;
  localparam int ADDR_W = 12;
  localparam int MAX_BYTES = 9600;
  localparam int AW1 = ADDR_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       rxd = '0;
  logic [1:0]        ben = '0;
  logic              rxda = 1'b0, rxsop = 1'b0, rxeop = 1'b0, rxdv = 1'b0;
  logic              rqrd, buf_we, desc_valid;
  logic              desc_ready = 1'b1;
  logic [ADDR_W-1:0] buf_waddr, desc_start;
  logic [31:0]       buf_wdata;
  logic [AW1-1:0]    rptr = '0, buf_wptr;
  logic [15:0]       desc_len, drop_cnt;

  mac_rx_buf_wr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .mac_clk_i(clk), .mac_rst_n_i(rst_n), .mac_rxd_i(rxd), .mac_ben_i(ben),
    .mac_rxda_i(rxda), .mac_rxsop_i(rxsop), .mac_rxeop_i(rxeop), .mac_rxdv_i(rxdv),
    .mac_rxrqrd_o(rqrd), .buf_we_o(buf_we), .buf_waddr_o(buf_waddr),
    .buf_wdata_o(buf_wdata), .buf_rptr_i(rptr), .buf_wptr_o(buf_wptr),
    .desc_valid_o(desc_valid), .desc_ready_i(desc_ready), .desc_start_o(desc_start),
    .desc_len_o(desc_len), .drop_cnt_o(drop_cnt)
  );

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [ADDR_W-1:0] start; logic [15:0] len; } desc_t;

  wr_t            wq[$];
  desc_t          dq[$];
  logic [31:0]    frm_d[$];
  logic [31:0]    pre_d[$];
  logic [AW1-1:0] m_wptr = '0;
  int             m_drop = 0;
  int             tests = 0, fails = 0;
  int             rq_lat = 0;
  bit             mon_en = 1'b0;
  bit             ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write and every accepted descriptor is checked in order.
  always @(negedge clk) begin : mon
    wr_t w;
    desc_t d;
    if (rst_n && mon_en) begin
      if (buf_we) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_write: got addr 0x%0h, no write expected", buf_waddr);
        end else begin
          w = wq.pop_front();
          check("waddr", buf_waddr, w.addr);
          check("wdata", buf_wdata, w.data);
        end
      end
      if (desc_valid && desc_ready) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_desc: got start 0x%0h, no descriptor expected", desc_start);
        end else begin
          d = dq.pop_front();
          check("desc_start", desc_start, d.start);
          check("desc_len", desc_len, d.len);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (ready_rand) desc_ready = 1'($urandom);
  end

  task automatic set_ready(input logic v);
    @(posedge clk); #2; desc_ready = v;
    @(negedge clk);
  endtask

  // Frame-level model: a prefix of words is stored until space runs out or the
  // running length exceeds the limit; a complete good frame yields a descriptor.
  task automatic model_frame(input bit trunc, input logic [1:0] b);
    logic [31:0]    d[$];
    logic [AW1-1:0] used;
    logic [AW1-1:0] a;
    int n, free, w, rl, len;
    if (trunc) d = pre_d; else d = frm_d;
    n = d.size();
    used = m_wptr - rptr;
    free = DEPTH - int'(used);
    len = (n - 1) * 4 + int'(b) + 1;
    w = 0;
    for (int k = 1; k <= n; k++) begin
      rl = (k == n && !trunc) ? len : 4 * k;
      if (k > free || rl > MAX_BYTES) break;
      w = k;
    end
    for (int i = 0; i < w; i++) begin
      a = m_wptr + AW1'(i);
      wq.push_back('{addr: a[ADDR_W-1:0], data: d[i]});
    end
    if (!trunc && w == n) begin
      dq.push_back('{start: m_wptr[ADDR_W-1:0], len: 16'(len)});
      m_wptr = m_wptr + AW1'(n);
    end else if (m_drop < 65535) begin
      m_drop++;
    end
  endtask

  task automatic drive_word(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] b, input int gap);
    int g;
    g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    repeat (g) @(negedge clk);
    rxd = d; rxsop = s; rxeop = e; ben = e ? b : 2'($urandom); rxdv = 1'b1;
    @(negedge clk);
    rxdv = 1'b0; rxsop = 1'b0; rxeop = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] b, input int stray, input int gap);
    int to;
    to = 0;
    rxda = 1'b1;
    @(negedge clk);
    while (!rqrd && to < 1000) begin @(negedge clk); to++; end
    rq_lat = to + 1;
    if (!rqrd) begin
      tests++; fails++;
      $display("FAIL rqrd_timeout: got rqrd=0 after %0d cycles, expected 1", to);
      rxda = 1'b0;
      return;
    end
    for (int i = 0; i < stray; i++) drive_word($urandom, 1'b0, 1'b0, b, gap);
    foreach (pre_d[i]) drive_word(pre_d[i], i == 0, 1'b0, b, gap);
    foreach (frm_d[i]) drive_word(frm_d[i], i == 0, i == frm_d.size() - 1, b, gap);
    rxda = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [1:0] b, input int p,
                           input int stray, input int gap);
    frm_d.delete();
    pre_d.delete();
    for (int i = 0; i < p; i++) pre_d.push_back($urandom);
    for (int i = 0; i < n; i++) frm_d.push_back($urandom);
    if (p > 0) model_frame(1'b1, b);
    model_frame(1'b0, b);
    send_frame(b, stray, gap);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [AW1-1:0] a_end, b_start;
    int to, used_t, n, p, free;
    logic [1:0] b;

    repeat (3) @(negedge clk);
    check("rst_rqrd", rqrd, 0);
    check("rst_we", buf_we, 0);
    check("rst_wptr", buf_wptr, 0);
    check("rst_desc_valid", desc_valid, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 64-byte frame into an empty buffer
    run_frame(16, 2'b11, 0, 0, 0);
    check("rqrd_latency", rq_lat, 1);
    check("eop_plus1_valid", desc_valid, 0);
    check("eop_plus1_last_we", buf_we, 1);
    @(negedge clk);
    check("eop_plus2_valid", desc_valid, 1);
    check("first_desc_start", desc_start, 0);
    check("first_desc_len", desc_len, 64);
    check("first_wptr", buf_wptr, 16);

    // 9604-byte frame dropped, next frame lands at the old pointer
    rptr = m_wptr;
    run_frame(2401, 2'b11, 0, 0, 0);
    check("oversize_drop", drop_cnt, 1);
    check("oversize_wptr", buf_wptr, 16);
    run_frame(16, 2'b11, 0, 0, 0);
    @(negedge clk);
    check("after_oversize_wptr", buf_wptr, 32);

    // Advance the committed pointer to 4090, then a wrapping 61-byte frame
    rptr = m_wptr;
    run_frame(2400, 2'b11, 0, 0, 1);
    rptr = m_wptr;
    run_frame(1658, 2'b10, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("pre_wrap_wptr", buf_wptr, 4090);
    rptr = m_wptr;
    run_frame(16, 2'b00, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("wrap_wptr", buf_wptr, m_wptr);

    // Only 8 free words for a 20-word frame
    rptr = m_wptr - AW1'(DEPTH - 8);
    run_frame(20, 2'b11, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("full_drop", drop_cnt, m_drop);
    check("full_wptr", buf_wptr, m_wptr);
    check("full_no_desc", desc_valid, 0);

    // SOP on word 5, then a 10-word frame
    rptr = m_wptr;
    run_frame(10, 2'b11, 4, 0, 1);
    repeat (2) @(negedge clk);
    check("midsop_drop", drop_cnt, m_drop);
    check("midsop_wptr", buf_wptr, m_wptr);

    // Back-to-back frames with the descriptor consumer stalled
    set_ready(1'b0);
    run_frame(8, 2'b11, 0, 0, 0);
    a_end = m_wptr;
    b_start = m_wptr;
    run_frame(6, 2'b01, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("bp_rqrd", rqrd, 0);
    check("bp_valid", desc_valid, 1);
    check("bp_first_len", desc_len, 32);
    check("bp_wptr", buf_wptr, a_end);
    set_ready(1'b1);
    @(negedge clk);
    check("bp_second_start", desc_start, b_start[ADDR_W-1:0]);
    check("bp_second_len", desc_len, 22);
    check("bp_second_wptr", buf_wptr, m_wptr);

    // Randomised frames, gaps, backpressure and occupancy
    ready_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 40);
      b = 2'($urandom);
      used_t = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(1, 30))
                                           : int'($urandom_range(0, 1000));
      rptr = m_wptr - AW1'(used_t);
      free = DEPTH - used_t;
      p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      if (p > free) p = 0;
      run_frame(n, b, p, $urandom_range(0, 2), 2);
      check("rand_drop", drop_cnt, m_drop);
    end

    ready_rand = 1'b0;
    set_ready(1'b1);
    to = 0;
    while ((dq.size() != 0 || wq.size() != 0) && to < 100) begin @(negedge clk); to++; end
    check("desc_drain", dq.size(), 0);
    check("write_drain", wq.size(), 0);
    check("final_wptr", buf_wptr, m_wptr);
    check("final_drop", drop_cnt, m_drop);

    // Asynchronous reset in the middle of a frame
    mon_en = 1'b0;
    rxda = 1'b1;
    to = 0;
    @(negedge clk);
    while (!rqrd && to < 100) begin @(negedge clk); to++; end
    check("midrst_rqrd_up", rqrd, 1);
    for (int i = 0; i < 5; i++) drive_word($urandom, i == 0, 1'b0, 2'b00, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rqrd", rqrd, 0);
    check("midrst_we", buf_we, 0);
    check("midrst_waddr", buf_waddr, 0);
    check("midrst_wdata", buf_wdata, 0);
    check("midrst_wptr", buf_wptr, 0);
    check("midrst_valid", desc_valid, 0);
    check("midrst_start", desc_start, 0);
    check("midrst_len", desc_len, 0);
    check("midrst_drop", drop_cnt, 0);
    rxda = 1'b0;
    rptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_valid", desc_valid, 0);
    check("postrst_wptr", buf_wptr, 0);
    check("postrst_rqrd", rqrd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mac_rx_buf_wr.md
# mac_rx_buf_wr

Receive-side writer that drains frames from the tri-mode MAC RX interface into a circular 32-bit packet buffer and emits one descriptor per good frame to the downstream AXI read-out logic. It is the first stage after the MAC. It drives the MAC read request, packs byte counts from the final-word byte enable, and handles buffer overflow. It also drops oversize and malformed frames without corrupting committed data.

## Interface
- DEPTH, 4096: buffer depth in 32-bit words; power of two.
- ADDR_W, 12: log2(DEPTH).
- MAX_BYTES, 9600: frames longer than this are dropped.

Ports:
- mac_clk_i  in  1  MAC clock; all logic on rising edge.
- mac_rst_n_i  in  1  reset; asynchronous assert, active-low.
- mac_rxd_i  in  32  MAC RX data word.
- mac_ben_i  in  2  valid bytes on EOP word minus one (00=1 … 11=4).
- mac_rxda_i  in  1  MAC has at least one frame available.
- mac_rxsop_i  in  1  first word of frame.
- mac_rxeop_i  in  1  last word of frame.
- mac_rxdv_i  in  1  word valid this cycle.
- mac_rxrqrd_o  out  1  read request to MAC.
- buf_we_o  out  1  buffer write strobe.
- buf_waddr_o  out  ADDR_W  buffer write address.
- buf_wdata_o  out  32  buffer write data.
- buf_rptr_i  in  ADDR_W+1  consumer free pointer; words below it are released.
- buf_wptr_o  out  ADDR_W+1  committed write pointer.
- desc_valid_o  out  1  descriptor available.
- desc_ready_i  in  1  descriptor accepted when high with valid.
- desc_start_o  out  ADDR_W  first word address of frame.
- desc_len_o  out  16  frame length in bytes.
- drop_cnt_o  out  16  dropped-frame counter; saturates at 0xFFFF.

## Operation
- Pointers are ADDR_W+1 bits with wrap bit. Used = wptr_work − buf_rptr_i. Full when used == DEPTH.
- States: IDLE, READ, DROP, COMMIT.
- IDLE:
  - Enter READ when mac_rxda_i=1 and the buffer is not full.
  - On entry, wptr_work = buf_wptr_o and word count = 0.
- READ:
  - mac_rxrqrd_o=1.
  - Each mac_rxdv_i word is written at wptr_work[ADDR_W-1:0], then wptr_work increments.
  - A word with rxdv but no rxsop before the frame has started is discarded, not written.
  - Byte length = (words−1)·4 + mac_ben_i + 1, computed on the EOP word.
  - On EOP with length ≤ MAX_BYTES, go to COMMIT.
- Overflow: full at write time, or running length > MAX_BYTES. Go to DROP; the word that triggered it is not written.
- Unexpected SOP mid-frame:
  - Discard the partial frame and increment drop_cnt_o.
  - Rewind wptr_work to buf_wptr_o.
  - Restart the frame with this word; stay in READ.
- DROP:
  - mac_rxrqrd_o stays 1 to drain the MAC. All words are discarded.
  - On EOP: drop_cnt_o +1, wptr_work rewinds to buf_wptr_o, go to IDLE.
- COMMIT:
  - mac_rxrqrd_o=0.
  - If desc_valid_o=0, or desc_valid_o & desc_ready_i this cycle, load the descriptor, set buf_wptr_o=wptr_work and desc_valid_o=1, then go to IDLE.
  - Otherwise hold in COMMIT.
- desc_valid_o clears on desc_valid_o & desc_ready_i unless reloaded the same cycle.
- Reset, including mid-frame:
  - All outputs 0, state IDLE, pointers 0.
  - The partial frame is lost and no descriptor is issued.

## Timing
- mac_rxrqrd_o is registered. It rises 1 cycle after IDLE samples mac_rxda_i=1.
- It falls the cycle after the EOP word is sampled.
- MAC words may arrive on any cycle while mac_rxrqrd_o=1; rxdv gaps (MAC halt) are tolerated with no limit.
- Buffer write latency: word sampled at edge N → buf_we_o/addr/data valid in cycle N+1, one cycle wide.
- Descriptor latency: EOP sampled at N → last write in N+1 → desc_valid_o and buf_wptr_o update at N+2 at the earliest.
- Minimum frame-to-frame gap: 1 cycle in IDLE after COMMIT.
- buf_rptr_i is sampled every cycle. Space freed during READ is usable immediately.

## Test plan
- Single 64-byte frame (16 words, ben=11), buffer empty:
  - rxrqrd rises 1 cycle after rxda.
  - 16 writes at addresses 0–15.
  - desc start=0, len=64 two cycles after EOP; buf_wptr_o=16.
- 61-byte frame (16 words, ben=00) starting at wptr=4090 (DEPTH 4096):
  - Writes wrap to address 0–9.
  - desc start=4090, len=61.
- Buffer with 8 free words, 20-word frame:
  - 8 words written, then DROP drains the remaining 12 words.
  - drop_cnt_o=1, buf_wptr_o unchanged, no descriptor.
- Frame of 2401 words (9604 bytes) with MAX_BYTES=9600:
  - Dropped, drop_cnt_o+1.
  - The next 64-byte frame is committed at the old wptr.
- SOP at word 5 of a frame, then a 10-word frame:
  - drop_cnt_o=1.
  - Descriptor len=40 starting at the original wptr.
- desc_ready_i held low across two back-to-back frames:
  - Second frame holds in COMMIT with rxrqrd=0.
  - Releasing ready yields the second descriptor the next cycle.
- Reset pulse mid-frame: all outputs 0 asynchronously, no descriptor issued.
